// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions: datapath width, decoder opcodes, pipe-controller states.
// Pure declarations, no logic.
// Optional perf counters in the controller are enabled with PIPE_CTRL_PERF_EN.
package pipe_hazard_ctrl_pkg;

  localparam int cXLEN    = 32;
  localparam int cRegIdxW = 5;

  // Decoder operation classes; only the values the controller cares about are fixed here.
  typedef enum logic [3:0] {
    eNOOP   = 4'd0,
    eOpAlu  = 4'd1,
    eOpLoad = 4'd2,
    eOpStor = 4'd3,
    eOpBrch = 4'd4
  } eOpType;

  typedef enum logic [1:0] {
    eRun     = 2'd0,
    eLdStall = 2'd1,
    eMemWait = 2'd2,
    eFlush   = 2'd3
  } ePipeState;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the front end (fetch/decode/execute/mem) and the hazard controller.
// slave = controller side, master = pipeline side.
// With PIPE_CTRL_PERF_EN defined the three perf counters are carried here too.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic                iDecValid;
  logic [cRegIdxW-1:0] iDecRs1;
  logic [cRegIdxW-1:0] iDecRs2;
  logic [cRegIdxW-1:0] iDecRd;
  logic                iDecIsLoad;
  logic                iDecRs1En;
  logic                iDecRs2En;
  logic                iBranchTaken;
  logic [cXLEN-1:0]    iBranchTarget;
  logic                iMemBusy;
  logic                oFetchEn;
  logic                oDecEn;
  logic                oBubble;
  logic                oFlushPipe;
  logic                oPcLoad;
  logic [cXLEN-1:0]    oPcTarget;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]         oStallCnt;
  logic [31:0]         oFlushCnt;
  logic [31:0]         oFreezeCnt;

  modport slave (
    input  iDecValid, iDecRs1, iDecRs2, iDecRd, iDecIsLoad, iDecRs1En, iDecRs2En,
           iBranchTaken, iBranchTarget, iMemBusy,
    output oFetchEn, oDecEn, oBubble, oFlushPipe, oPcLoad, oPcTarget,
           oStallCnt, oFlushCnt, oFreezeCnt
  );
  modport master (
    output iDecValid, iDecRs1, iDecRs2, iDecRd, iDecIsLoad, iDecRs1En, iDecRs2En,
           iBranchTaken, iBranchTarget, iMemBusy,
    input  oFetchEn, oDecEn, oBubble, oFlushPipe, oPcLoad, oPcTarget,
           oStallCnt, oFlushCnt, oFreezeCnt
  );
`else
  modport slave (
    input  iDecValid, iDecRs1, iDecRs2, iDecRd, iDecIsLoad, iDecRs1En, iDecRs2En,
           iBranchTaken, iBranchTarget, iMemBusy,
    output oFetchEn, oDecEn, oBubble, oFlushPipe, oPcLoad, oPcTarget
  );
  modport master (
    output iDecValid, iDecRs1, iDecRs2, iDecRd, iDecIsLoad, iDecRs1En, iDecRs2En,
           iBranchTaken, iBranchTarget, iMemBusy,
    input  oFetchEn, oDecEn, oBubble, oFlushPipe, oPcLoad, oPcTarget
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags a decoded instruction that reads the pending load's rd.
// Latency: combinational, zero cycles.
// No backpressure of its own; x0 as destination never raises a hazard.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                iDecValid,
  input  logic [cRegIdxW-1:0] iRs1,
  input  logic                iRs1En,
  input  logic [cRegIdxW-1:0] iRs2,
  input  logic                iRs2En,
  input  logic [cRegIdxW-1:0] iLdRd,
  input  logic                iLdPend,
  output logic                oHazard
);

  logic rs1Hit;
  logic rs2Hit;

  assign rs1Hit  = iRs1En && (iRs1 == iLdRd);
  assign rs2Hit  = iRs2En && (iRs2 == iLdRd);
  assign oHazard = iDecValid && iLdPend && (iLdRd != '0) && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer: advance/hold/flush fetch+decode, load-use bubbles, branch redirect.
// Latency: enables/bubble combinational (0 cycles); pc load/target/flush registered (1 cycle).
// Backpressure: iMemBusy freezes the pipe (all enables low); PIPE_CTRL_PERF_EN adds perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int cFlushCycles = 2,
  parameter int cLoadStall   = 1
)(
  input logic               iClk,
  input logic               iRst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] cStRun     = eRun;
  localparam logic [1:0] cStLdStall = eLdStall;
  localparam logic [1:0] cStMemWait = eMemWait;
  localparam logic [1:0] cStFlush   = eFlush;

  localparam int cCntMax = (cFlushCycles > cLoadStall) ? cFlushCycles : cLoadStall;
  localparam int cCntW   = (cCntMax < 2) ? 1 : $clog2(cCntMax);

  logic [1:0]          state, nState;
  logic [1:0]          retState, nRetState;
  logic [1:0]          effState;
  logic [cCntW-1:0]    cnt, nCnt;
  logic                ldPend, nLdPend;
  logic [cRegIdxW-1:0] ldRd, nLdRd;
  logic                pcLoad;
  logic [cXLEN-1:0]    pcTarget;
  logic                flush;
  logic                hazard;
  logic                fetchEn, decEn, bubble;

  hazard_detect u_hazard_detect (
    .iDecValid (bus.iDecValid),
    .iRs1      (bus.iDecRs1),
    .iRs1En    (bus.iDecRs1En),
    .iRs2      (bus.iDecRs2),
    .iRs2En    (bus.iDecRs2En),
    .iLdRd     (ldRd),
    .iLdPend   (ldPend),
    .oHazard   (hazard)
  );

  // MEMWAIT is a parking state: once memory frees up we behave as the interrupted
  // state in that very cycle, so a freeze lasts exactly as long as iMemBusy.
  assign effState = (state == cStMemWait) ? retState : state;

  // Front-end enables and bubble from state plus same-cycle hazard / memory busy.
  always_comb begin
    fetchEn = 1'b0;
    decEn   = 1'b0;
    bubble  = 1'b0;
    if (!iRst) begin
      case (effState)
        cStRun: begin
          if (!bus.iMemBusy) begin
            if (hazard) begin
              bubble = 1'b1;
            end else begin
              fetchEn = 1'b1;
              decEn   = 1'b1;
            end
          end
        end
        cStLdStall: bubble  = !bus.iMemBusy;
        cStFlush:   fetchEn = !pcLoad;  // fetch resumes once the new PC is loaded
        default: ;
      endcase
    end
  end

  // Next state, stall/flush counter and pending-load tracker; branch beats busy beats hazard.
  always_comb begin
    nState    = state;
    nRetState = retState;
    nCnt      = cnt;
    nLdPend   = ldPend;
    nLdRd     = ldRd;
    if (bus.iBranchTaken) begin
      nState  = cStFlush;
      nCnt    = cCntW'(cFlushCycles - 1);
      nLdPend = 1'b0;
    end else begin
      case (effState)
        cStRun: begin
          if (bus.iMemBusy) begin
            nState    = cStMemWait;
            nRetState = cStRun;
          end else if (hazard) begin
            // The hazard cycle is the first bubble; LDSTALL covers the rest.
            if (cLoadStall > 1) begin
              nState = cStLdStall;
              nCnt   = cCntW'(cLoadStall - 1);
            end else begin
              nState  = cStRun;
              nLdPend = 1'b0;
            end
          end else begin
            // Whatever sat in execute moves on; track a load leaving decode.
            nState  = cStRun;
            nLdPend = bus.iDecValid && decEn && bus.iDecIsLoad;
            nLdRd   = bus.iDecRd;
          end
        end
        cStLdStall: begin
          if (bus.iMemBusy) begin
            nState    = cStMemWait;
            nRetState = cStLdStall;
          end else if (cnt <= cCntW'(1)) begin
            // cnt holds the stall cycles left including this one
            nState  = cStRun;
            nCnt    = '0;
            nLdPend = 1'b0;
          end else begin
            nState = cStLdStall;
            nCnt   = cnt - 1'b1;
          end
        end
        cStFlush: begin
          if (cnt == '0) begin
            nState    = bus.iMemBusy ? cStMemWait : cStRun;
            nRetState = cStRun;
          end else begin
            nCnt = cnt - 1'b1;
          end
        end
        default: nState = cStRun;
      endcase
    end
  end

  // State registers and the registered redirect/flush outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= cStRun;
      retState <= cStRun;
      cnt      <= '0;
      ldPend   <= 1'b0;
      ldRd     <= '0;
      pcLoad   <= 1'b0;
      pcTarget <= '0;
      flush    <= 1'b0;
    end else begin
      state    <= nState;
      retState <= nRetState;
      cnt      <= nCnt;
      ldPend   <= nLdPend;
      ldRd     <= nLdRd;
      pcLoad   <= bus.iBranchTaken;
      if (bus.iBranchTaken) begin
        pcTarget <= bus.iBranchTarget;
      end
      flush    <= (nState == cStFlush);
    end
  end

  assign bus.oFetchEn   = fetchEn;
  assign bus.oDecEn     = decEn;
  assign bus.oBubble    = bubble;
  assign bus.oFlushPipe = flush;
  assign bus.oPcLoad    = pcLoad;
  assign bus.oPcTarget  = pcTarget;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt, flushCnt, freezeCnt;

  // Saturating perf counters: stall cycles, branch events, memory-freeze cycles.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stallCnt  <= '0;
      flushCnt  <= '0;
      freezeCnt <= '0;
    end else begin
      if ((state == cStLdStall) && (stallCnt != '1)) stallCnt <= stallCnt + 32'd1;
      if (bus.iBranchTaken && (flushCnt != '1))      flushCnt <= flushCnt + 32'd1;
      if ((state == cStMemWait) && (freezeCnt != '1)) freezeCnt <= freezeCnt + 32'd1;
    end
  end

  assign bus.oStallCnt  = stallCnt;
  assign bus.oFlushCnt  = flushCnt;
  assign bus.oFreezeCnt = freezeCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector tables plus reset-abort sequence.
// Two instances: default parameters, and cLoadStall=3 for the stall/freeze interplay.
// Inputs driven on the falling edge, outputs sampled 1 ns later.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl_if bus3();

  pipe_hazard_ctrl #(.cFlushCycles(2), .cLoadStall(1)) dut (
    .iClk(iClk), .iRst(iRst), .bus(bus.slave)
  );
  pipe_hazard_ctrl #(.cFlushCycles(2), .cLoadStall(3)) dut3 (
    .iClk(iClk), .iRst(iRst), .bus(bus3.slave)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        e1;
    logic [4:0]  rs2;
    logic        e2;
    logic [4:0]  rd;
    logic        ld;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic        fe, de, bub, fl, pl;
    logic [31:0] pt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tab[29];
  vec_t tab3[9];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic e1, logic [4:0] rs2, logic e2,
                              logic [4:0] rd, logic ld, logic br, logic [31:0] tgt, logic busy,
                              logic fe, logic de, logic bub, logic fl, logic pl, logic [31:0] pt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.e1 = e1; t.rs2 = rs2; t.e2 = e2; t.rd = rd; t.ld = ld;
    t.br = br; t.tgt = tgt; t.busy = busy;
    t.fe = fe; t.de = de; t.bub = bub; t.fl = fl; t.pl = pl; t.pt = pt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Same stimulus goes to both instances.
  task automatic apply(input vec_t t);
    bus.iDecValid  = t.v;  bus3.iDecValid  = t.v;
    bus.iDecRs1    = t.rs1; bus3.iDecRs1   = t.rs1;
    bus.iDecRs1En  = t.e1; bus3.iDecRs1En  = t.e1;
    bus.iDecRs2    = t.rs2; bus3.iDecRs2   = t.rs2;
    bus.iDecRs2En  = t.e2; bus3.iDecRs2En  = t.e2;
    bus.iDecRd     = t.rd; bus3.iDecRd     = t.rd;
    bus.iDecIsLoad = t.ld; bus3.iDecIsLoad = t.ld;
    bus.iBranchTaken  = t.br;  bus3.iBranchTaken  = t.br;
    bus.iBranchTarget = t.tgt; bus3.iBranchTarget = t.tgt;
    bus.iMemBusy   = t.busy; bus3.iMemBusy = t.busy;
  endtask

  task automatic check_vec(input string tag, input int idx, input vec_t t, input bit third);
    if (third) begin
      chk($sformatf("%s%0d fetchEn", tag, idx), 32'(bus3.oFetchEn),   32'(t.fe));
      chk($sformatf("%s%0d decEn",   tag, idx), 32'(bus3.oDecEn),     32'(t.de));
      chk($sformatf("%s%0d bubble",  tag, idx), 32'(bus3.oBubble),    32'(t.bub));
      chk($sformatf("%s%0d flush",   tag, idx), 32'(bus3.oFlushPipe), 32'(t.fl));
      chk($sformatf("%s%0d pcLoad",  tag, idx), 32'(bus3.oPcLoad),    32'(t.pl));
      chk($sformatf("%s%0d pcTgt",   tag, idx), bus3.oPcTarget,       t.pt);
    end else begin
      chk($sformatf("%s%0d fetchEn", tag, idx), 32'(bus.oFetchEn),   32'(t.fe));
      chk($sformatf("%s%0d decEn",   tag, idx), 32'(bus.oDecEn),     32'(t.de));
      chk($sformatf("%s%0d bubble",  tag, idx), 32'(bus.oBubble),    32'(t.bub));
      chk($sformatf("%s%0d flush",   tag, idx), 32'(bus.oFlushPipe), 32'(t.fl));
      chk($sformatf("%s%0d pcLoad",  tag, idx), 32'(bus.oPcLoad),    32'(t.pl));
      chk($sformatf("%s%0d pcTgt",   tag, idx), bus.oPcTarget,       t.pt);
    end
  endtask

  initial begin
    vec_t idle, rst0;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0);
    rst0 = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);

    // Default instance (cFlushCycles=2, cLoadStall=1)
    //           v rs1 e1 rs2 e2 rd ld br tgt  busy  fe de bub fl pl pt
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // first cycle after reset
    tab[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // load x5
    tab[2]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 0,     0,   0, 0, 1, 0, 0, 0);      // uses x5 -> 1 bubble
    tab[3]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // proceeds
    tab[4]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // load x0
    tab[5]  = mk(1, 0, 1, 0, 0, 6, 0, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // reads x0: no hazard
    tab[6]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // load x7
    tab[7]  = mk(1, 3, 1, 7, 0, 8, 0, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // rs2=x7 not read
    tab[8]  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,     0,   1, 1, 0, 0, 0, 0);      // load x9
    tab[9]  = mk(1, 0, 0, 9, 1, 2, 0, 0, 0,     0,   0, 0, 1, 0, 0, 0);      // rs2 hazard
    tab[10] = idle;
    tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 1, 1, 0, 0, 0, 0);      // branch
    tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   0, 0, 0, 1, 1, 32'h100);
    tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 0, 0, 1, 0, 32'h100);
    tab[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 1, 0, 0, 0, 32'h100);
    tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1,   0, 0, 0, 0, 0, 32'h100); // mem busy
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1,   0, 0, 0, 0, 0, 32'h100);
    tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 1, 0, 0, 0, 32'h100);
    tab[18] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0,     0,   1, 1, 0, 0, 0, 32'h100); // load x4
    tab[19] = mk(1, 4, 1, 0, 0, 6, 0, 1, 32'h200, 1, 0, 0, 0, 0, 0, 32'h100); // branch+busy+hazard
    tab[20] = mk(1, 4, 1, 0, 0, 6, 0, 0, 0,     1,   0, 0, 0, 1, 1, 32'h200);
    tab[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     1,   1, 0, 0, 1, 0, 32'h200);
    tab[22] = mk(1, 4, 1, 0, 0, 6, 0, 0, 0,     1,   0, 0, 0, 0, 0, 32'h200); // MEMWAIT after flush
    tab[23] = mk(1, 4, 1, 0, 0, 6, 0, 0, 0,     0,   1, 1, 0, 0, 0, 32'h200); // ldPend was cleared
    tab[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 1, 1, 0, 0, 0, 32'h200);
    tab[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 1, 1, 32'h300); // branch in FLUSH
    tab[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   0, 0, 0, 1, 1, 32'h400);
    tab[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 0, 0, 1, 0, 32'h400);
    tab[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 1, 0, 0, 0, 32'h400);

    // cLoadStall=3 instance: busy for 3 cycles in the middle of a load stall
    tab3[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tab3[1] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);  // bubble 1
    tab3[2] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);  // bubble 2
    tab3[3] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // frozen
    tab3[4] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    tab3[5] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    tab3[6] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);  // bubble 3
    tab3[7] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tab3[8] = mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);

    // Reset state
    iRst = 1'b1;
    apply(idle);
    repeat (2) @(posedge iClk);
    #1;
    check_vec("rst", 0, rst0, 0);
    check_vec("rst3_", 0, rst0, 1);
    @(negedge iClk);
    iRst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(negedge iClk);
      apply(tab[i]);
      #1;
      check_vec("row", i, tab[i], 0);
    end

    // Reset asserted mid-flush aborts at once and leaves no pulse behind
    @(negedge iClk);
    apply(mk(0,0,0,0,0,0,0,1,32'h500,0, 1,1,0,0,0,0));
    @(negedge iClk);
    apply(idle);
    #1;
    chk("midflush pcLoad", 32'(bus.oPcLoad), 32'd1);
    chk("midflush flush", 32'(bus.oFlushPipe), 32'd1);
    chk("midflush pcTgt", bus.oPcTarget, 32'h500);
    iRst = 1'b1;
    #1;
    check_vec("abort", 0, rst0, 0);
    @(negedge iClk);
    iRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      #1;
      check_vec("postrst", i, idle, 0);
    end

    // Stall interrupted by memory busy
    for (int i = 0; i < 9; i++) begin
      @(negedge iClk);
      apply(tab3[i]);
      #1;
      check_vec("ls3_", i, tab3[i], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller placed around `instDecoder`. It decides each cycle whether fetch and decode advance, hold or are flushed. It detects load-use hazards from the decoder's register fields and freezes the front end while memory is busy. On a taken branch it drives the decoder's flush input and redirects the PC.

## Interface
Parameters:
- `cFlushCycles`, default 2: cycles `oFlushPipe` stays high after a taken branch. Must equal the decoder `cycleNum`.
- `cLoadStall`, default 1: bubble cycles inserted per load-use hazard, range 1..3.

Ports:
- `iClk` in 1: clock. One clock domain only.
- `iRst` in 1: asynchronous, active-high reset.
- `iDecValid` in 1: decoder output holds a valid instruction.
- `iDecRs1` in 5, `iDecRs2` in 5: source register indices of the decoded instruction.
- `iDecRd` in 5: destination register index of the decoded instruction.
- `iDecIsLoad` in 1: the decoded instruction is a load (`eOpLoad`).
- `iDecRs1En` in 1, `iDecRs2En` in 1: the corresponding source field is actually read.
- `iBranchTaken` in 1: execute stage resolved a taken branch or jump. Single-cycle pulse.
- `iBranchTarget` in `cXLEN`: redirect address, valid together with `iBranchTaken`.
- `iMemBusy` in 1: memory stage cannot accept; freeze the pipe.
- `oFetchEn` out 1: fetch may advance the PC.
- `oDecEn` out 1: decoder may capture a new instruction.
- `oBubble` out 1: insert a NOP into execute this cycle.
- `oFlushPipe` out 1: drives decoder `iFlushPipe`.
- `oPcLoad` out 1: one-cycle pulse; fetch loads `oPcTarget`.
- `oPcTarget` out `cXLEN`: registered redirect address.

## Operation
- FSM states:
  - `RUN`: normal operation.
  - `LDSTALL`: bubble countdown, `cLoadStall` cycles.
  - `MEMWAIT`: hold until `iMemBusy` drops.
  - `FLUSH`: flush countdown, `cFlushCycles` cycles.
- Pending-load tracker: `ldPend` and `ldRd`. Loaded when an instruction with `iDecIsLoad` leaves decode (`iDecValid & oDecEn`). Cleared when the load advances past execute.
- Load-use hazard condition, all of the following true:
  - `iDecValid`
  - `ldPend`
  - `ldRd != 0`
  - `(iDecRs1En & iDecRs1 == ldRd)` or `(iDecRs2En & iDecRs2 == ldRd)`
- Event priority, highest first: `iBranchTaken`, then `iMemBusy`, then load-use.
- `RUN`:
  - Fetch and decode enabled.
  - Hazard: deassert `oFetchEn` and `oDecEn`, assert `oBubble`, go to `LDSTALL` with the counter at `cLoadStall-1`.
- `LDSTALL`:
  - Fetch and decode held, `oBubble` high.
  - Count down; at 0 return to `RUN` and clear `ldPend`.
- `MEMWAIT`:
  - All enables low and `oBubble` low; pipe contents preserved.
  - Return to the state that was interrupted. An `LDSTALL` count does not decrement while in `MEMWAIT`.
- Branch, from any state including `MEMWAIT`:
  - Register `iBranchTarget` into `oPcTarget` and pulse `oPcLoad`.
  - Assert `oFlushPipe` for `cFlushCycles` cycles and clear `ldPend`.
  - `oDecEn` stays low during `FLUSH`. `oFetchEn` is high from the cycle after `oPcLoad`.
  - At count end go to `RUN`, or to `MEMWAIT` if `iMemBusy` is high.
- A branch during `FLUSH` restarts the count and reloads the target.
- `rd == x0` never creates a hazard.

## Timing
- Reset (`iRst` high, asynchronous):
  - All outputs 0, state `RUN`, `ldPend` 0, counters 0.
  - `oFetchEn` and `oDecEn` read 1 in the first cycle after release.
- `oFetchEn`, `oDecEn`, `oBubble`: combinational from state plus same-cycle hazard and `iMemBusy`. Hazard response has zero latency.
- `oPcLoad`, `oPcTarget`, `oFlushPipe`: registered. They rise 1 cycle after `iBranchTaken`.
- `oFlushPipe` is high for exactly `cFlushCycles` consecutive cycles.
- Reset asserted mid-flush or mid-stall aborts immediately. No pulse is emitted after release.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds three 32-bit counters: `oStallCnt` (cycles in `LDSTALL`), `oFlushCnt` (branch events) and `oFreezeCnt` (cycles in `MEMWAIT`).
  - All cleared by `iRst` and saturate at all-ones.
- Not defined: the ports are absent and the counters are not built.

## Structure
- The shared core package (alongside `cXLEN`, `eOpLoad`, `eNOOP`) holds:
  - `typedef enum logic [1:0] ePipeState {eRun, eLdStall, eMemWait, eFlush}`
  - register-index width constant `cRegIdxW = 5`
- One sub-module, `hazard_detect`: combinational load-use comparator taking rs1/rs2/enables/ldRd/ldPend and producing the hazard flag.

## Test plan
- Reset release with no stimulus -> `oFetchEn=1`, `oDecEn=1` on the first clock; `oBubble=0`, `oFlushPipe=0`.
- Load `rd=5` decoded, next instruction `rs1=5` (`rs1En=1`), `cLoadStall=1` -> `oBubble=1` and `oFetchEn=0` for exactly 1 cycle, then `RUN`.
- Same sequence with `rd=0` -> no bubble, enables stay 1.
- `iBranchTaken` with target `0x0000_0100`, `cFlushCycles=2` -> next cycle `oPcLoad=1` and `oPcTarget=0x100`; `oFlushPipe` high 2 cycles, then `RUN`.
- `iMemBusy` high 3 cycles during `LDSTALL` -> enables 0, `oBubble` 0 for 3 cycles, then the stall completes its remaining cycles.
- `iBranchTaken` asserted in the same cycle as a load-use hazard and `iMemBusy` -> branch wins; flush sequence runs, `ldPend` is cleared, and the FSM enters `MEMWAIT` after the flush because `iMemBusy` is still high.
